// File: rtl/path_gen_pkg.sv
// path_gen_pkg
// Shared types, constants and helpers for the path generator pipeline.
//   state_t   : batch controller states (IDLE / RUN / DRAIN)
//   ONE       : fixed-point 1.0 for the default FRAC of 12
//   sat_u     : clamp a signed value into the unsigned range [0, 2^w-1]
package path_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned DEF_FRAC = 12;
  localparam logic [31:0] ONE      = 32'd1 << DEF_FRAC;

  // Negative values become 0, values above 2^w-1 become 2^w-1.
  // Valid for w up to 62.
  function automatic logic [63:0] sat_u(input logic signed [63:0] x,
                                        input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    if (x < 0) begin
      return 64'd0;
    end else if (x > $signed(max_v)) begin
      return max_v;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/path_gen_pipe_fx_mul_sat.sv
// fx_mul_sat
// Fixed-point multiply: a (signed or unsigned, W bits) times b (unsigned,
// W bits), arithmetic shift right by FRAC. With SAT=1 the result is clamped
// to the unsigned OW-bit range; with SAT=0 it is the raw shifted product
// truncated to OW bits (use OW = 2W+2 for full precision).
// Ports:
//   a : W-bit multiplicand, two's complement when A_SIGNED=1
//   b : W-bit unsigned multiplier
//   y : OW-bit result
module fx_mul_sat
  import path_gen_pkg::*;
#(
  parameter int W        = 16,
  parameter int FRAC     = 12,
  parameter bit A_SIGNED = 1'b0,
  parameter bit SAT      = 1'b0,
  parameter int OW       = W
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [OW-1:0] y
);

  logic signed [W:0]     a_ext;
  logic signed [W:0]     b_ext;
  logic signed [2*W+1:0] prod;
  logic signed [2*W+1:0] prod_sh;

  // One extra bit on each operand lets an unsigned operand use its full
  // range inside a signed multiply.
  always_comb begin
    a_ext   = A_SIGNED ? $signed({a[W-1], a}) : $signed({1'b0, a});
    b_ext   = $signed({1'b0, b});
    prod    = a_ext * b_ext;
    prod_sh = prod >>> FRAC;
  end

  if (SAT) begin : g_sat
    assign y = OW'(sat_u(64'(prod_sh), OW));
  end else begin : g_raw
    assign y = prod_sh[OW-1:0];
  end

endmodule

// File: rtl/path_gen_pipe.sv
// path_gen_pipe
// Generates NPATH interleaved price paths of NDAYS steps each. Every
// accepted random sample eps advances one path by one day:
//   m = (vol*eps) >>> FRAC, g = clamp(drift + m), price = sat(price*g >> FRAC)
// Three register stages (m, g, output) give a 3-cycle sample-to-output latency.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   start, s0, drift, vol       : batch request and its parameters (IDLE only)
//   eps_valid, eps, eps_ready   : random-sample stream
//   out_valid, out_ready        : output handshake
//   out_price/out_path/out_day  : updated price with its tags
//   out_last                    : final output of the batch
//   busy                        : batch in progress
module path_gen_pipe
  import path_gen_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int NPATH = 4,
  parameter int NDAYS = 16,
  localparam int PW   = (NPATH > 1) ? $clog2(NPATH) : 1,
  localparam int DW   = (NDAYS > 1) ? $clog2(NDAYS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  s0,
  input  logic [W-1:0]  drift,
  input  logic [W-1:0]  vol,
  input  logic          eps_valid,
  input  logic [W-1:0]  eps,
  output logic          eps_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_price,
  output logic [PW-1:0] out_path,
  output logic [DW-1:0] out_day,
  output logic          out_last,
  output logic          busy
);

  localparam logic [PW-1:0] LAST_PATH = PW'(NPATH - 1);
  localparam logic [DW-1:0] LAST_DAY  = DW'(NDAYS - 1);

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic [W-1:0]          drift_q, drift_d;
  logic [W-1:0]          vol_q, vol_d;
  logic [PW-1:0]         path_q, path_d;
  logic [DW-1:0]         day_q, day_d;
  logic [W-1:0]          price_q [NPATH];
  logic [W-1:0]          price_d [NPATH];

  logic                  s1_valid_q, s1_valid_d;
  logic signed [2*W+1:0] s1_m_q, s1_m_d;
  logic [PW-1:0]         s1_path_q, s1_path_d;
  logic [DW-1:0]         s1_day_q, s1_day_d;
  logic                  s1_last_q, s1_last_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [W-1:0]          s2_g_q, s2_g_d;
  logic [PW-1:0]         s2_path_q, s2_path_d;
  logic [DW-1:0]         s2_day_q, s2_day_d;
  logic                  s2_last_q, s2_last_d;

  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          out_price_q, out_price_d;
  logic [PW-1:0]         out_path_q, out_path_d;
  logic [DW-1:0]         out_day_q, out_day_d;
  logic                  out_last_q, out_last_d;

  logic                  stall;
  logic                  accept;
  logic                  last_sample;
  logic signed [2*W+1:0] m_full;
  logic signed [2*W+2:0] g_sum;
  logic [W-1:0]          g_clamped;
  logic [W-1:0]          price_new;

  fx_mul_sat #(
    .W(W), .FRAC(FRAC), .A_SIGNED(1'b1), .SAT(1'b0), .OW(2*W+2)
  ) u_stage1 (
    .a(eps),
    .b(vol_q),
    .y(m_full)
  );

  fx_mul_sat #(
    .W(W), .FRAC(FRAC), .A_SIGNED(1'b0), .SAT(1'b1), .OW(W)
  ) u_stage3 (
    .a(price_q[s2_path_q]),
    .b(s2_g_q),
    .y(price_new)
  );

  assign stall       = out_valid_q && !out_ready;
  assign eps_ready   = (state_q == RUN) && !stall;
  assign accept      = eps_valid && eps_ready;
  assign last_sample = (path_q == LAST_PATH) && (day_q == LAST_DAY);

  // drift is unsigned; m is the full signed stage-1 product.
  assign g_sum     = $signed({{(W+3){1'b0}}, drift_q}) + {s1_m_q[2*W+1], s1_m_q};
  assign g_clamped = W'(sat_u(64'(g_sum), W));

  assign out_valid = out_valid_q;
  assign out_price = out_price_q;
  assign out_path  = out_path_q;
  assign out_day   = out_day_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

  // Controller and pipeline next-state. A stall freezes every stage and the
  // price array, so a path's price is read and written back in the same
  // stage and consecutive updates of one path always see the latest value.
  always_comb begin
    state_d     = state_q;
    drift_d     = drift_q;
    vol_d       = vol_q;
    path_d      = path_q;
    day_d       = day_q;
    price_d     = price_q;
    s1_valid_d  = s1_valid_q;
    s1_m_d      = s1_m_q;
    s1_path_d   = s1_path_q;
    s1_day_d    = s1_day_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_g_d      = s2_g_q;
    s2_path_d   = s2_path_q;
    s2_day_d    = s2_day_q;
    s2_last_d   = s2_last_q;
    out_valid_d = out_valid_q;
    out_price_d = out_price_q;
    out_path_d  = out_path_q;
    out_day_d   = out_day_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          drift_d = drift;
          vol_d   = vol;
          path_d  = '0;
          day_d   = '0;
          for (int p = 0; p < NPATH; p++) begin
            price_d[p] = s0;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (last_sample) begin
            state_d = DRAIN;
          end
          if (path_q == LAST_PATH) begin
            path_d = '0;
            day_d  = day_q + DW'(1);
          end else begin
            path_d = path_q + PW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready && out_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!stall) begin
      s1_valid_d  = accept;
      s1_m_d      = m_full;
      s1_path_d   = path_q;
      s1_day_d    = day_q;
      s1_last_d   = last_sample;
      s2_valid_d  = s1_valid_q;
      s2_g_d      = g_clamped;
      s2_path_d   = s1_path_q;
      s2_day_d    = s1_day_q;
      s2_last_d   = s1_last_q;
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_price_d          = price_new;
        out_path_d           = s2_path_q;
        out_day_d            = s2_day_q;
        out_last_d           = s2_last_q;
        price_d[s2_path_q]   = price_new;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State registers; reset abandons any batch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      drift_q     <= '0;
      vol_q       <= '0;
      path_q      <= '0;
      day_q       <= '0;
      for (int p = 0; p < NPATH; p++) begin
        price_q[p] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_m_q      <= '0;
      s1_path_q   <= '0;
      s1_day_q    <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_g_q      <= '0;
      s2_path_q   <= '0;
      s2_day_q    <= '0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_price_q <= '0;
      out_path_q  <= '0;
      out_day_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      drift_q     <= drift_d;
      vol_q       <= vol_d;
      path_q      <= path_d;
      day_q       <= day_d;
      price_q     <= price_d;
      s1_valid_q  <= s1_valid_d;
      s1_m_q      <= s1_m_d;
      s1_path_q   <= s1_path_d;
      s1_day_q    <= s1_day_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_g_q      <= s2_g_d;
      s2_path_q   <= s2_path_d;
      s2_day_q    <= s2_day_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
      out_price_q <= out_price_d;
      out_path_q  <= out_path_d;
      out_day_q   <= out_day_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_path_gen_pipe.sv
// tb_path_gen_pipe
// Directed bench for path_gen_pipe (W=16, FRAC=12, NPATH=4, NDAYS=16).
// Each batch streams 64 samples and compares every output against
// hand-computed prices and the expected path/day/last tags.
module tb_path_gen_pipe;
  import path_gen_pkg::*;

  localparam int NOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] s0;
  logic [15:0] drift;
  logic [15:0] vol;
  logic        eps_valid;
  logic [15:0] eps;
  logic        eps_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_price;
  logic [1:0]  out_path;
  logic [3:0]  out_day;
  logic        out_last;
  logic        busy;

  int check_count;
  int fail_count;

  path_gen_pipe #(
    .W(16), .FRAC(12), .NPATH(4), .NDAYS(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .s0(s0),
    .drift(drift),
    .vol(vol),
    .eps_valid(eps_valid),
    .eps(eps),
    .eps_ready(eps_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_price(out_price),
    .out_path(out_path),
    .out_day(out_day),
    .out_last(out_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Hand-computed prices. Mode 1: g = 1.0 + 1.0*0.5 = 1.5 each day from 1.0.
  // Mode 2: path 1 gets g clamped to 0 on day 0, others keep g = 1.0.
  function automatic int expPrice(input int mode, input int p, input int d);
    if (mode == 1) begin
      case (d)
        0: return 6144;
        1: return 9216;
        2: return 13824;
        3: return 20736;
        4: return 31104;
        5: return 46656;
        default: return 65535;
      endcase
    end else if (mode == 2) begin
      return (p == 1) ? 0 : 4096;
    end
    return 4096;
  endfunction

  // Mode 0 uses large eps of both signs; vol is 0 so they must not matter.
  function automatic logic [15:0] epsFor(input int mode, input int idx);
    if (mode == 1) begin
      return 16'd2048;
    end else if (mode == 2) begin
      if (idx == 1) return 16'hE000;
      if (idx % 4 == 1) return 16'd2048;
      return 16'd0;
    end
    return idx[0] ? 16'(-30000 + idx * 7) : 16'(30000 - idx * 11);
  endfunction

  // Pulses start for one cycle with the given batch parameters.
  task automatic applyStimulus(input logic [15:0] s0_v, input logic [15:0] drift_v,
                               input logic [15:0] vol_v);
    @(negedge clk);
    s0    = s0_v;
    drift = drift_v;
    vol   = vol_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams one batch. stall_at: output index at which out_ready drops for
  // 10 cycles; poke_at: sample index at which start is re-pulsed with new
  // parameters; reset_at: sample index at which reset is asserted. -1 = off.
  task automatic runBatch(input int mode, input int stall_at, input int poke_at,
                          input int reset_at);
    int  in_idx;
    int  out_idx;
    int  cyc;
    int  stall_left;
    int  first_acc;
    int  first_out;
    bit  stalled;
    bit  poked;
    in_idx     = 0;
    out_idx    = 0;
    cyc        = 0;
    stall_left = 0;
    first_acc  = -1;
    first_out  = -1;
    stalled    = 1'b0;
    poked      = 1'b0;
    while (out_idx < NOUT && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke_at >= 0 && !poked && in_idx == poke_at) begin
        start = 1'b1;
        s0    = 16'd100;
        drift = 16'd8192;
        vol   = 16'd4096;
        poked = 1'b1;
      end
      if (reset_at >= 0 && in_idx == reset_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_price", int'(out_price), 0);
        checkOutput("rst_out_day", int'(out_day), 0);
        checkOutput("rst_eps_ready", int'(eps_ready), 0);
        checkOutput("rst_busy", int'(busy), 0);
        eps_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (stall_at >= 0 && !stalled && out_idx == stall_at) begin
        stalled    = 1'b1;
        stall_left = 10;
      end
      out_ready = (stall_left == 0);
      eps_valid = (in_idx < NOUT);
      eps       = epsFor(mode, in_idx);
      #1;
      if (first_out < 0 && out_valid) first_out = cyc;
      if (stall_left > 0) begin
        checkOutput("stall_eps_ready", int'(eps_ready), 0);
        checkOutput("stall_out_valid", int'(out_valid), 1);
        checkOutput("stall_price", int'(out_price), expPrice(mode, out_idx % 4, out_idx / 4));
        checkOutput("stall_path", int'(out_path), out_idx % 4);
        stall_left--;
      end
      if (out_valid && out_ready) begin
        checkOutput("price", int'(out_price), expPrice(mode, out_idx % 4, out_idx / 4));
        checkOutput("path", int'(out_path), out_idx % 4);
        checkOutput("day", int'(out_day), out_idx / 4);
        checkOutput("last", int'(out_last), (out_idx == NOUT - 1) ? 1 : 0);
        out_idx++;
      end
      if (eps_valid && eps_ready) begin
        if (first_acc < 0) first_acc = cyc;
        in_idx++;
      end
    end
    checkOutput("out_count", out_idx, NOUT);
    checkOutput("latency", first_out - first_acc, 3);
    eps_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("end_busy", int'(busy), 0);
    checkOutput("end_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    check_count = 0;
    fail_count  = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    s0          = '0;
    drift       = '0;
    vol         = '0;
    eps_valid   = 1'b0;
    eps         = '0;
    out_ready   = 1'b1;
    #1;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_eps_ready", int'(eps_ready), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_out_price", int'(out_price), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] batch: flat prices, vol = 0");
    applyStimulus(16'(ONE), 16'd4096, 16'd0);
    checkOutput("busy_after_start", int'(busy), 1);
    runBatch(0, -1, -1, -1);

    $display("[TB] batch: growth 1.5x with saturation");
    applyStimulus(16'd4096, 16'd4096, 16'd4096);
    runBatch(1, -1, -1, -1);

    $display("[TB] batch: path 1 clamped to zero");
    applyStimulus(16'd4096, 16'd4096, 16'd4096);
    runBatch(2, -1, -1, -1);

    $display("[TB] batch: 10-cycle downstream stall");
    applyStimulus(16'd4096, 16'd4096, 16'd4096);
    runBatch(1, 20, -1, -1);

    $display("[TB] batch: reset during day 5, then fresh batch");
    applyStimulus(16'd4096, 16'd4096, 16'd4096);
    runBatch(1, -1, -1, 21);
    applyStimulus(16'd4096, 16'd4096, 16'd4096);
    runBatch(1, -1, -1, -1);

    $display("[TB] batch: start re-pulsed while running");
    applyStimulus(16'd4096, 16'd4096, 16'd0);
    runBatch(0, -1, 10, -1);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
